hazard_unit_mc: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It extends the basic forwarding, load-use and branch-flush logic with a multi-cycle mul/div occupancy FSM in EX and a data-memory wait stall. It sits beside the datapath and drives all stage stall and flush enables.

---
 rtl/hazard_unit_mc.sv | 174 +++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core: forwarding, load-use, branch flush,
// multi-cycle mul/div occupancy and data-memory wait. Define HAZARD_PERF_EN for perf counters.
module hazard_unit_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  ResultSrcE0,
  input  logic                  MulDivE,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  DMemReadyM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW,
  output logic                  MdBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           StallCycles,
  output logic [31:0]           FlushCount
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_e;

  // A latency of 1 never stalls, so the load value is only meaningful above 1.
  localparam bit               MD_STALLS = (MULDIV_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MD_STALLS ? MULDIV_LAT - 2 : 0);

  mdState_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             memStall, mdStall, lwStall, branchTaken;

  function automatic logic [1:0] forwardSel(
    input logic [REG_ADDR_W-1:0] srcIdx,
    input logic [REG_ADDR_W-1:0] memRd,
    input logic [REG_ADDR_W-1:0] wbRd,
    input logic                  memWe,
    input logic                  wbWe
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (srcIdx != '0) begin
      if (memWe && (srcIdx == memRd)) begin
        sel = 2'b10;
      end else if (wbWe && (srcIdx == wbRd)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hazard detection in priority order; a memory wait freezes the occupancy FSM entirely.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mdStall     = 1'b0;
    memStall    = MemReqM && !DMemReadyM;
    if (!memStall) begin
      if (state_q == IDLE) begin
        if (MulDivE && MD_STALLS) begin
          mdStall = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end else begin
        if (cnt_q != '0) begin
          mdStall = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
    end
    branchTaken = !memStall && !mdStall && PCSrcE;
    lwStall     = !memStall && !mdStall && ResultSrcE0 && (RdE != '0) &&
                  ((Rs1D == RdE) || (Rs2D == RdE));
  end

  // A taken branch wins over load-use so the PC is free to load the target.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = forwardSel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
      ForwardBE = forwardSel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
      if (memStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (mdStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (branchTaken) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lwStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign MdBusy = (state_q == BUSY);

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCycles_q, flushCount_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      if (StallF && (stallCycles_q != '1)) begin
        stallCycles_q <= stallCycles_q + 32'd1;
      end
      if (branchTaken && (flushCount_q != '1)) begin
        flushCount_q <= flushCount_q + 32'd1;
      end
    end
  end

  assign StallCycles = stallCycles_q;
  assign FlushCount  = flushCount_q;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed cases plus randomized cycles
// compared against a cycle-count based reference model.
module tb_hazard_unit_mc;
  localparam int LAT = 4;

  typedef struct packed {
    logic       rstN;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regWriteM, regWriteW, load, mulDiv, pcSrc, memReq, memReady;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic       RegWriteM = 0, RegWriteW = 0, ResultSrcE0 = 0, MulDivE = 0, PCSrcE = 0;
  logic       MemReqM = 0, DMemReadyM = 1;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdBusy;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  hazard_unit_mc #(.REG_ADDR_W(5), .MULDIV_LAT(LAT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .MulDivE(MulDivE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .DMemReadyM(DMemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MdBusy(MdBusy)
`ifdef HAZARD_PERF_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycleNum      = 0;

  // Reference state: occupancy cycles already spent by the mul/div in EX, plus perf totals.
  int          occDone     = 0;
  logic [31:0] modelStalls = '0;
  logic [31:0] modelFlushes = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cycleNum, observed, expected);
    end
  endtask

  function automatic logic [1:0] refForward(input logic [4:0] src, input stim_t s);
    if (src == 0) return 2'b00;
    if (s.regWriteM && src == s.rdM) return 2'b10;
    if (s.regWriteW && src == s.rdW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkAgainstModel(input stim_t s);
    logic memS, mdS, br, lw, xStallF;
    logic [3:0] expStall, expFlush;
    if (!s.rstN) begin
      occDone = 0;
      modelStalls = '0;
      modelFlushes = '0;
      checkOutput("fwdA", {30'd0, ForwardAE}, 32'd0);
      checkOutput("fwdB", {30'd0, ForwardBE}, 32'd0);
      checkOutput("stalls", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
      checkOutput("flushes", {28'd0, FlushD, FlushE, FlushM, FlushW}, 32'hF);
      checkOutput("busy", {31'd0, MdBusy}, 32'd0);
`ifdef HAZARD_PERF_EN
      checkOutput("perfStall", StallCycles, 32'd0);
      checkOutput("perfFlush", FlushCount, 32'd0);
`endif
      return;
    end
    memS = s.memReq && !s.memReady;
    mdS  = !memS && (occDone > 0 || s.mulDiv) && (occDone + 1 < LAT);
    br   = !memS && !mdS && s.pcSrc;
    lw   = !memS && !mdS && s.load && s.rdE != 0 && (s.rs1D == s.rdE || s.rs2D == s.rdE);
    xStallF  = memS || mdS || (lw && !br);
    expStall = {xStallF, xStallF, memS || mdS, memS};
    expFlush = {br, br || lw, mdS, memS};
    checkOutput("fwdA", {30'd0, ForwardAE}, {30'd0, refForward(s.rs1E, s)});
    checkOutput("fwdB", {30'd0, ForwardBE}, {30'd0, refForward(s.rs2E, s)});
    checkOutput("stalls", {28'd0, StallF, StallD, StallE, StallM}, {28'd0, expStall});
    checkOutput("flushes", {28'd0, FlushD, FlushE, FlushM, FlushW}, {28'd0, expFlush});
    checkOutput("busy", {31'd0, MdBusy}, {31'd0, occDone > 0});
`ifdef HAZARD_PERF_EN
    checkOutput("perfStall", StallCycles, modelStalls);
    checkOutput("perfFlush", FlushCount, modelFlushes);
`endif
    if (xStallF && modelStalls != 32'hFFFF_FFFF) modelStalls++;
    if (br && modelFlushes != 32'hFFFF_FFFF) modelFlushes++;
    if (!memS && (occDone > 0 || s.mulDiv)) begin
      occDone++;
      if (occDone >= LAT) occDone = 0;
    end
  endtask

  // Drives one cycle's inputs just after the edge, then checks mid-cycle.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = s.rstN; Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
    RdE = s.rdE; RdM = s.rdM; RdW = s.rdW; RegWriteM = s.regWriteM; RegWriteW = s.regWriteW;
    ResultSrcE0 = s.load; MulDivE = s.mulDiv; PCSrcE = s.pcSrc;
    MemReqM = s.memReq; DMemReadyM = s.memReady;
    #3;
    cycleNum++;
    checkAgainstModel(s);
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    s.rstN = 1'b1;
    s.memReady = 1'b1;
    return s;
  endfunction

  initial begin
    stim_t s;
    int cnt, memCnt;

    s = quiet(); s.rstN = 1'b0;
    applyStimulus(s);
    applyStimulus(s);

    s = quiet(); s.rs1E = 5; s.rdM = 5; s.regWriteM = 1; s.rdW = 5; s.regWriteW = 1;
    applyStimulus(s);
    checkOutput("tp_fwdA_mem", {30'd0, ForwardAE}, 32'd2);
    s.rs1E = 0;
    applyStimulus(s);
    checkOutput("tp_fwdA_x0", {30'd0, ForwardAE}, 32'd0);
    s = quiet(); s.rs2E = 9; s.rdW = 9; s.regWriteW = 1;
    applyStimulus(s);
    checkOutput("tp_fwdB_wb", {30'd0, ForwardBE}, 32'd1);

    s = quiet(); s.load = 1; s.rdE = 7; s.rs2D = 7;
    applyStimulus(s);
    checkOutput("tp_lw", {29'd0, StallF, StallD, FlushE}, 32'h7);
    s.rdE = 0; s.rs2D = 0;
    applyStimulus(s);
    checkOutput("tp_lw_x0", {29'd0, StallF, StallD, FlushE}, 32'h0);

    cnt = 0;
    for (int i = 0; i < LAT; i++) begin
      s = quiet(); s.mulDiv = 1;
      applyStimulus(s);
      if (FlushM && StallE) cnt++;
    end
    checkOutput("tp_md_stalls", cnt, LAT - 1);
    applyStimulus(quiet());
    checkOutput("tp_md_idle", {31'd0, MdBusy}, 32'd0);

    cnt = 0; memCnt = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      s = quiet(); s.mulDiv = 1;
      if (i == 1 || i == 2) begin s.memReq = 1; s.memReady = 0; end
      applyStimulus(s);
      if (FlushM) cnt++;
      if (FlushW && StallM) memCnt++;
    end
    checkOutput("tp_mem_md_stalls", cnt, LAT - 1);
    checkOutput("tp_mem_stalls", memCnt, 2);
    checkOutput("tp_mem_md_done", {31'd0, MdBusy}, 32'd1);
    applyStimulus(quiet());
    checkOutput("tp_mem_md_idle", {31'd0, MdBusy}, 32'd0);

    s = quiet(); s.load = 1; s.rdE = 3; s.rs1D = 3; s.pcSrc = 1;
    applyStimulus(s);
    checkOutput("tp_br_lw", {28'd0, FlushD, FlushE, StallF, StallD}, 32'hC);
    s = quiet(); s.mulDiv = 1; s.pcSrc = 1;
    applyStimulus(s);
    checkOutput("tp_br_md", {30'd0, FlushD, StallF}, 32'h1);
    s.pcSrc = 0;
    for (int i = 1; i < LAT; i++) applyStimulus(s);

    s = quiet(); s.mulDiv = 1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(s);
    s.rstN = 1'b0;
    applyStimulus(s);
    checkOutput("tp_rst_busy", {31'd0, MdBusy}, 32'd0);
    cnt = 0;
    for (int i = 0; i < LAT; i++) begin
      s = quiet(); s.mulDiv = 1;
      applyStimulus(s);
      if (FlushM) cnt++;
    end
    checkOutput("tp_rst_full", cnt, LAT - 1);

    for (int i = 0; i < 600; i++) begin
      s.rstN      = ($urandom_range(0, 59) != 0);
      s.rs1D      = 5'($urandom_range(0, 3));
      s.rs2D      = 5'($urandom_range(0, 3));
      s.rs1E      = 5'($urandom_range(0, 3));
      s.rs2E      = 5'($urandom_range(0, 3));
      s.rdE       = 5'($urandom_range(0, 3));
      s.rdM       = 5'($urandom_range(0, 3));
      s.rdW       = 5'($urandom_range(0, 3));
      s.regWriteM = 1'($urandom_range(0, 1));
      s.regWriteW = 1'($urandom_range(0, 1));
      s.load      = ($urandom_range(0, 2) == 0);
      s.mulDiv    = ($urandom_range(0, 3) == 0);
      s.pcSrc     = ($urandom_range(0, 7) == 0);
      s.memReq    = ($urandom_range(0, 2) == 0);
      s.memReady  = 1'($urandom_range(0, 1));
      applyStimulus(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
